// File: rtl/fir_ofc_uart_packer_if.sv
// Byte-stream packer bus: groups the sample sink (from the FIR_ofc filter) and
// the byte source (toward the UART transmitter) into one bundle.
//   sink_data   filtered sample, signed two's complement, IN_W bits
//   sink_valid  sample qualifier (no backpressure toward the filter)
//   sink_error  2-bit filter error flags
//   out_data    byte toward UART TX
//   out_valid   out_data valid
//   out_ready   UART TX accepts the byte
// slave  = packer view (consumes samples, produces bytes)
// master = environment view (produces samples, consumes bytes)
interface fir_ofc_uart_packer_if #(
  parameter int IN_W = 36
);
  logic [IN_W-1:0] sink_data;
  logic            sink_valid;
  logic [1:0]      sink_error;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  sink_data, sink_valid, sink_error, out_ready,
    output out_data, out_valid
  );

  modport master (
    output sink_data, sink_valid, sink_error, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/fir_ofc_uart_packer.sv
// Rounds, scales and saturates the 36-bit filtered sample stream to 16 bits,
// buffers it in a sample FIFO and serializes each sample as a 3-byte frame
// (header, data[15:8], data[7:0]) on a valid/ready byte stream for the UART.
// Header byte = {4'hA, sat, ovf, err[1:0]}.
// Ports:
//   clk_clk      system clock, rising edge
//   rst_reset_n  asynchronous active-low reset
//   bus          packer bus (slave modport): sink_* in, out_* byte stream
//   ovf_sticky   a sample was dropped since the last reported header
//   fifo_level   current FIFO occupancy
//
// Serializer states:
//   state | meaning
//   IDLE  | nothing presented, waiting for a FIFO word
//   B0    | header byte presented
//   B1    | data[15:8] presented
//   B2    | data[7:0] presented; next frame loads on transfer if one is waiting
module fir_ofc_uart_packer #(
  parameter int IN_W       = 36,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk_clk,
  input  logic                  rst_reset_n,
  fir_ofc_uart_packer_if.slave  bus,
  output logic                  ovf_sticky,
  output logic [ADDR_W:0]       fifo_level
);

  localparam int WORD_W = OUT_W + 3;

  // One extra bit so adding the rounding constant can never wrap.
  typedef logic signed [IN_W:0] wide_t;
  localparam wide_t RND  = wide_t'(1) <<< (SHIFT - 1);
  localparam wide_t MAXV = wide_t'((2 ** (OUT_W - 1)) - 1);
  localparam wide_t MINV = wide_t'(-(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  // ---------------- stage 1: round half-up, arithmetic shift
  wide_t       sum, shifted, s1_val;
  logic        s1_valid;
  logic [1:0]  s1_err;

  always_comb begin
    sum     = wide_t'($signed(bus.sink_data)) + RND;
    shifted = sum >>> SHIFT;
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_err   <= '0;
    end else begin
      s1_valid <= bus.sink_valid;
      if (bus.sink_valid) begin
        s1_val <= shifted;
        s1_err <= bus.sink_error;
      end
    end
  end

  // ---------------- stage 2: saturate and write into the FIFO
  logic              sat;
  logic [OUT_W-1:0]  data16;
  logic [WORD_W-1:0] wr_word, rd_word;

  always_comb begin
    sat    = 1'b0;
    data16 = s1_val[OUT_W-1:0];
    if (s1_val > MAXV) begin
      sat    = 1'b1;
      data16 = SAT_HI;
    end else if (s1_val < MINV) begin
      sat    = 1'b1;
      data16 = SAT_LO;
    end
    wr_word = {s1_err, sat, data16};
  end

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full, empty, push, drop, pop;

  assign full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Fullness is judged before a same-cycle pop, so a write at full drops.
  assign push  = s1_valid && !full;
  assign drop  = s1_valid && full;
  assign rd_word = mem[rd_ptr];

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      // A drop in the cycle the flag is reported keeps it set.
      if (drop)     ovf_sticky <= 1'b1;
      else if (pop) ovf_sticky <= 1'b0;
    end
  end

  assign fifo_level = count;

  // ---------------- byte serializer
  state_t      state, state_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] data_q, data_d;
  logic        xfer, load;

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      state       <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state       <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    pop         = 1'b0;
    load        = 1'b0;
    xfer        = out_valid_q && bus.out_ready;
    unique case (state)
      IDLE: load = !empty;
      B0: if (xfer) begin
        out_data_d = data_q[15:8];
        state_d    = B1;
      end
      B1: if (xfer) begin
        out_data_d = data_q[7:0];
        state_d    = B2;
      end
      B2: if (xfer) begin
        if (!empty) begin
          load = 1'b1;
        end else begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Header is frozen at pop time, including the current overflow flag.
    if (load) begin
      pop         = 1'b1;
      data_d      = rd_word[15:0];
      out_data_d  = {4'hA, rd_word[OUT_W], ovf_sticky, rd_word[OUT_W+2:OUT_W+1]};
      out_valid_d = 1'b1;
      state_d     = B0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_ofc_uart_packer.sv
module tb_fir_ofc_uart_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ovf_sticky;
  logic [4:0] fifo_level;

  fir_ofc_uart_packer_if #(.IN_W(36)) bus ();

  fir_ofc_uart_packer #(
    .IN_W(36), .OUT_W(16), .SHIFT(12), .FIFO_DEPTH(16), .ADDR_W(4)
  ) dut (
    .clk_clk     (clk),
    .rst_reset_n (rst_n),
    .bus         (bus),
    .ovf_sticky  (ovf_sticky),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] d;
    logic [1:0]  e;
    logic [23:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          gaps   = 0;
  bit          gap_mon = 1'b0;
  bit          pend = 1'b0;
  bit          rnd_done = 1'b0;
  logic [7:0]  pend_data = '0;
  logic [7:0]  rx_q [$];
  logic [23:0] expf [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte collector and hold-stability check, sampled away from the clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend)
        chk("hold_stable", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, pend_data});
      if (gap_mon && !bus.out_valid) gaps++;
      if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data);
      pend      = bus.out_valid && !bus.out_ready;
      pend_data = bus.out_data;
    end
  end

  // Reference: round half-up, divide by 4096 (floor), clip to 16 bits.
  function automatic logic [23:0] model_frame(logic [35:0] d, logic [1:0] e, logic ovf);
    longint     v, q;
    logic       sat;
    logic [63:0] t;
    v   = longint'($signed(d));
    q   = (v + 2048) >>> 12;
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767; sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; sat = 1'b1;
    end
    t = 64'(q);
    return {4'hA, sat, ovf, e, t[15:0]};
  endfunction

  function automatic logic [35:0] rand_sample();
    logic [63:0] t;
    longint      v;
    if ($urandom_range(0, 3) == 0) begin
      t = {$urandom(), $urandom()};
      return t[35:0];
    end
    v = longint'($urandom_range(0, 32'h0FFF_FFFF)) - 64'sh0800_0000;
    t = 64'(v);
    return t[35:0];
  endfunction

  task automatic send(logic [35:0] d, logic [1:0] e);
    @(posedge clk); #1;
    bus.sink_data  = d;
    bus.sink_error = e;
    bus.sink_valid = 1'b1;
    @(posedge clk); #1;
    bus.sink_valid = 1'b0;
  endtask

  task automatic wait_rx(int n, int budget, string nm);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (rx_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d bytes, expected %0d", nm, rx_q.size(), n);
    end
  endtask

  task automatic pop_frame(output logic [23:0] f);
    logic [7:0] b0, b1, b2;
    if (rx_q.size() < 3) begin
      f = '0;
    end else begin
      b0 = rx_q.pop_front();
      b1 = rx_q.pop_front();
      b2 = rx_q.pop_front();
      f  = {b0, b1, b2};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t        tbl [13];
  logic [23:0] f;
  logic [35:0] d;
  logic [1:0]  e;

  initial begin
    tbl[0]  = '{36'd4096,         2'd0, 24'hA00001};
    tbl[1]  = '{36'd2048,         2'd0, 24'hA00001};
    tbl[2]  = '{36'd2047,         2'd0, 24'hA00000};
    tbl[3]  = '{36'hF_FFFF_F000,  2'd0, 24'hA0FFFF};
    tbl[4]  = '{36'h7_FFFF_FFFF,  2'd0, 24'hA87FFF};
    tbl[5]  = '{36'h8_0000_0000,  2'd0, 24'hA88000};
    tbl[6]  = '{36'd0,            2'd2, 24'hA20000};
    tbl[7]  = '{36'hF_FFFF_F800,  2'd0, 24'hA00000};
    tbl[8]  = '{36'hF_FFFF_F7FF,  2'd0, 24'hA0FFFF};
    tbl[9]  = '{36'h0_07FF_F000,  2'd3, 24'hA37FFF};
    tbl[10] = '{36'h0_07FF_F800,  2'd1, 24'hA97FFF};
    tbl[11] = '{36'hF_F800_0000,  2'd0, 24'hA08000};
    tbl[12] = '{36'hF_F7FF_F7FF,  2'd0, 24'hA88000};

    rst_n          = 1'b0;
    bus.sink_valid = 1'b0;
    bus.sink_data  = '0;
    bus.sink_error = '0;
    bus.out_ready  = 1'b1;

    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_ovf",       32'(ovf_sticky),    32'd0);
    chk("rst_level",     32'(fifo_level),    32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: header appears three cycles after the sample.
    send(36'd4096, 2'd0);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n3_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_n3_hdr",   32'(bus.out_data),  32'hA0);
    wait_rx(3, 20, "lat_rx");
    pop_frame(f);
    chk("lat_frame", 32'(f), 32'hA00001);

    // Rounding, saturation and error pass-through table.
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].d, tbl[i].e);
      wait_rx(3, 30, $sformatf("vec%0d_rx", i));
      pop_frame(f);
      chk($sformatf("vec%0d_frame", i), 32'(f), 32'(tbl[i].exp));
    end
    chk("tbl_ovf", 32'(ovf_sticky), 32'd0);

    // Overflow: 20 samples back to back with the UART stalled.
    rx_q.delete();
    @(posedge clk); #1 bus.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus.sink_data  = 36'(k * 4096);
      bus.sink_error = 2'd0;
      bus.sink_valid = 1'b1;
    end
    @(posedge clk); #1 bus.sink_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_level_full", 32'(fifo_level),    32'd16);
    chk("ovf_sticky_set", 32'(ovf_sticky),    32'd1);
    chk("ovf_held_valid", 32'(bus.out_valid), 32'd1);
    chk("ovf_held_hdr",   32'(bus.out_data),  32'hA0);
    bus.out_ready = 1'b1;
    wait_rx(51, 200, "ovf_rx");
    for (int k = 0; k < 17; k++) begin
      pop_frame(f);
      chk($sformatf("ovf_frame%0d", k), 32'(f), 32'(model_frame(36'(k * 4096), 2'd0, k == 1)));
    end
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_no_extra", 32'(rx_q.size()), 32'd0);
    chk("ovf_cleared",  32'(ovf_sticky),  32'd0);
    chk("ovf_empty",    32'(fifo_level),  32'd0);

    // Back-to-back: random samples every third cycle, stream must not gap.
    rx_q.delete();
    expf.delete();
    gaps = 0;
    fork
      begin
        for (int k = 0; k < 50; k++) begin
          d = rand_sample();
          e = 2'($urandom_range(0, 3));
          expf.push_back(model_frame(d, e, 1'b0));
          @(posedge clk); #1;
          bus.sink_data  = d;
          bus.sink_error = e;
          bus.sink_valid = 1'b1;
          @(posedge clk); #1;
          bus.sink_valid = 1'b0;
          @(posedge clk);
        end
      end
      begin
        wait_rx(1, 20, "b2b_first");
        gap_mon = 1'b1;
        wait_rx(150, 300, "b2b_rx");
        gap_mon = 1'b0;
      end
    join
    chk("b2b_gaps", 32'(gaps), 32'd0);
    for (int k = 0; k < 50; k++) begin
      pop_frame(f);
      chk($sformatf("b2b_frame%0d", k), 32'(f), 32'(expf[k]));
    end
    chk("b2b_ovf", 32'(ovf_sticky), 32'd0);

    // Random backpressure with random sample spacing.
    rx_q.delete();
    expf.delete();
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          d = rand_sample();
          e = 2'($urandom_range(0, 3));
          expf.push_back(model_frame(d, e, 1'b0));
          send(d, e);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        wait_rx(48, 800, "bp_rx");
        rnd_done = 1'b1;
      end
    join
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pop_frame(f);
      chk($sformatf("bp_frame%0d", k), 32'(f), 32'(expf[k]));
    end
    chk("bp_ovf", 32'(ovf_sticky), 32'd0);

    // Reset in the middle of a frame.
    rx_q.delete();
    send(36'h0_0123_4000, 2'd1);
    wait_rx(2, 20, "rst_mid_rx");
    #1;
    chk("rst_mid_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_data",  32'(bus.out_data),  32'd0);
    chk("rst_mid_level", 32'(fifo_level),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_bytes", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      chk("rst_mid_hdr",   32'(rx_q[0]), 32'hA1);
      chk("rst_mid_byte1", 32'(rx_q[1]), 32'h12);
    end
    rx_q.delete();
    send(36'd256, 2'd0);
    wait_rx(3, 20, "rst_after1_rx");
    pop_frame(f);
    chk("rst_after1_frame", 32'(f), 32'hA00000);
    send(36'd8192, 2'd0);
    wait_rx(3, 20, "rst_after2_rx");
    pop_frame(f);
    chk("rst_after2_frame", 32'(f), 32'hA00002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
